// File: rtl/audio_eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_eth_pkg
// Description : Shared types and constants for the audio-over-Ethernet packer.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_eth_pkg;

  // Write FSM: one idle state plus one state per serialised byte
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB0  = 3'd1,
    WB1  = 3'd2,
    WB2  = 3'd3,
    WB3  = 3'd4
  } wr_state_t;

  localparam int DEF_PKT_BYTES = 1024;  // payload bytes per UDP packet
  localparam int SYNC_PULSE    = 4;     // pkt_sync high time in cycles
  localparam int OVF_W         = 16;    // width of the dropped-sample counter

endpackage
`default_nettype wire

// File: rtl/byte_fifo_sc.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo_sc
// Description : Single-clock circular byte FIFO, one slot kept empty, with
//               registered (non-FWFT) read data and registered occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo_sc #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] count
);

  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_count;
  logic [7:0]        r_rd_data;
  logic              w_rd_ok;

  // Reads against an empty FIFO are ignored; the writer never overfills it
  assign w_rd_ok = rd_en && (r_count != '0);
  assign rd_data = r_rd_data;
  assign count   = r_count;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= 8'h00;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      unique case ({wr_en, w_rd_ok})
        2'b10:   r_count <= r_count + ADDR_W'(1);
        2'b01:   r_count <= r_count - ADDR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_udp_packer.sv
`default_nettype none
// ============================================================================
// Module      : audio_udp_packer
// Description : Serialises stereo PCM samples into a byte FIFO for the UDP
//               transmit controller and generates packet/frame sync strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_udp_packer
  import audio_eth_pkg::*;
#(
  parameter int PKT_BYTES  = DEF_PKT_BYTES,
  parameter int FRAME_PKTS = 16,
  parameter int SYNC_LEN   = 16,
  parameter int ADDR_W     = 11
) (
  input  logic              gmii_tx_clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              sample_valid,
  input  logic [15:0]       sample_l,
  input  logic [15:0]       sample_r,
  output logic              sample_ready,
  input  logic              fifo_rd_en,
  output logic [7:0]        fifo_data,
  output logic [ADDR_W-1:0] fifo_data_count,
  output logic [15:0]       udp_send_data_length,
  output logic              pkt_sync,
  output logic              frame_sync,
  output logic [OVF_W-1:0]  overflow_cnt
);

  // A sample is accepted only with at least 4 free slots (capacity 2^ADDR_W-1)
  localparam logic [ADDR_W-1:0] SPACE_LIM = ADDR_W'((1 << ADDR_W) - 5);

  wr_state_t          r_state;
  wr_state_t          w_next_state;
  logic [31:0]        r_sample;
  logic               w_accept;
  logic               w_drop;
  logic               w_wr_en;
  logic [7:0]         w_wr_byte;
  logic [15:0]        r_byte_cnt;
  logic [15:0]        r_pkt_cnt;
  logic               r_pkt_wrap;
  logic               r_frame_wrap;
  logic [2:0]         r_pkt_timer;
  logic [15:0]        r_frame_timer;
  logic [OVF_W-1:0]   r_ovf;

  assign sample_ready         = (r_state == IDLE);
  assign udp_send_data_length = 16'(PKT_BYTES);
  assign pkt_sync             = (r_pkt_timer != 3'd0);
  assign frame_sync           = (r_frame_timer != 16'd0);
  assign overflow_cnt         = r_ovf;

  byte_fifo_sc #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (gmii_tx_clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (w_wr_en),
    .wr_data (w_wr_byte),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_data),
    .count   (fifo_data_count)
  );

  // Write FSM state register
  always_ff @(posedge gmii_tx_clk) begin
    if (rst || flush) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, byte selection and accept/drop decision
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_byte    = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (sample_valid) begin
          if (fifo_data_count <= SPACE_LIM) begin
            w_accept     = 1'b1;
            w_next_state = WB0;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      WB0: begin
        w_wr_en      = 1'b1;
        w_wr_byte    = r_sample[7:0];
        w_drop       = sample_valid;
        w_next_state = WB1;
      end
      WB1: begin
        w_wr_en      = 1'b1;
        w_wr_byte    = r_sample[15:8];
        w_drop       = sample_valid;
        w_next_state = WB2;
      end
      WB2: begin
        w_wr_en      = 1'b1;
        w_wr_byte    = r_sample[23:16];
        w_drop       = sample_valid;
        w_next_state = WB3;
      end
      WB3: begin
        w_wr_en      = 1'b1;
        w_wr_byte    = r_sample[31:24];
        w_drop       = sample_valid;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the accepted stereo sample, left channel in the low half
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      r_sample <= 32'h0;
    end else if (w_accept) begin
      r_sample <= {sample_r, sample_l};
    end
  end

  // Written-byte and packet counters; wrap flags delay the strobes by one edge
  always_ff @(posedge gmii_tx_clk) begin
    if (rst || flush) begin
      r_byte_cnt   <= 16'd0;
      r_pkt_cnt    <= 16'd0;
      r_pkt_wrap   <= 1'b0;
      r_frame_wrap <= 1'b0;
    end else begin
      r_pkt_wrap   <= 1'b0;
      r_frame_wrap <= 1'b0;
      if (w_wr_en) begin
        if (r_byte_cnt == 16'(PKT_BYTES - 1)) begin
          r_byte_cnt <= 16'd0;
          r_pkt_wrap <= 1'b1;
          if (r_pkt_cnt == 16'(FRAME_PKTS - 1)) begin
            r_pkt_cnt    <= 16'd0;
            r_frame_wrap <= 1'b1;
          end else begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end
        end else begin
          r_byte_cnt <= r_byte_cnt + 16'd1;
        end
      end
    end
  end

  // Sync pulse timers; a new wrap reloads an active pulse
  always_ff @(posedge gmii_tx_clk) begin
    if (rst || flush) begin
      r_pkt_timer   <= 3'd0;
      r_frame_timer <= 16'd0;
    end else begin
      if (r_pkt_wrap) begin
        r_pkt_timer <= 3'(SYNC_PULSE);
      end else if (r_pkt_timer != 3'd0) begin
        r_pkt_timer <= r_pkt_timer - 3'd1;
      end
      if (r_frame_wrap) begin
        r_frame_timer <= 16'(SYNC_LEN);
      end else if (r_frame_timer != 16'd0) begin
        r_frame_timer <= r_frame_timer - 16'd1;
      end
    end
  end

  // Saturating count of dropped samples; survives flush
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (!flush && w_drop && (r_ovf != '1)) begin
      r_ovf <= r_ovf + OVF_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_udp_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_udp_packer
// Description : Self-checking bench for audio_udp_packer: table of byte-order
//               vectors, a byte scoreboard and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_udp_packer;

  logic        gmii_tx_clk;
  logic        rst;
  logic        flush;
  logic        sample_valid;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_ready;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic [10:0] fifo_data_count;
  logic [15:0] udp_send_data_length;
  logic        pkt_sync;
  logic        frame_sync;
  logic [15:0] overflow_cnt;

  audio_udp_packer dut (
    .gmii_tx_clk          (gmii_tx_clk),
    .rst                  (rst),
    .flush                (flush),
    .sample_valid         (sample_valid),
    .sample_l             (sample_l),
    .sample_r             (sample_r),
    .sample_ready         (sample_ready),
    .fifo_rd_en           (fifo_rd_en),
    .fifo_data            (fifo_data),
    .fifo_data_count      (fifo_data_count),
    .udp_send_data_length (udp_send_data_length),
    .pkt_sync             (pkt_sync),
    .frame_sync           (frame_sync),
    .overflow_cnt         (overflow_cnt)
  );

  initial gmii_tx_clk = 1'b0;
  always #5 gmii_tx_clk = ~gmii_tx_clk;

  typedef struct {
    logic [15:0]      l;
    logic [15:0]      r;
    logic [3:0][7:0]  exp;   // exp[0] is the first byte out of the FIFO
  } vec_t;

  vec_t vecs [4];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] q[$];
  int         m_count = 0;
  int         m_busy  = 0;
  int         m_ovf   = 0;
  int         m_bytes = 0;
  logic [7:0] m_data  = 8'h00;

  // Sync monitor state
  int   cyc = 0;
  int   last_wrap = -10;
  int   pkt_rises = 0;
  int   pkt_hi = 0;
  int   frame_rises = 0;
  int   frame_hi = 0;
  int   frame_at_pulse = 0;
  logic prev_pkt = 1'b0;
  logic prev_frame = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock: update the model from driven inputs, then compare
  task automatic tick();
    bit wrap_now;
    bit acc;
    bit rd_eff;
    bit pkt_rise;
    wrap_now = 1'b0;
    if (flush) begin
      m_count = 0;
      m_busy  = 0;
      m_bytes = 0;
      q.delete();
    end else begin
      acc    = sample_valid && (m_busy == 0) && (m_count <= 2043);
      rd_eff = fifo_rd_en && (m_count > 0);
      if (sample_valid && !acc && (m_ovf < 65535)) m_ovf++;
      if (rd_eff) begin
        m_data = q.pop_front();
        m_count--;
      end
      if (m_busy > 0) begin
        m_count++;
        m_busy--;
        m_bytes++;
        if (m_bytes == 1024) begin
          m_bytes  = 0;
          wrap_now = 1'b1;
        end
      end
      if (acc) begin
        m_busy = 4;
        q.push_back(sample_l[7:0]);
        q.push_back(sample_l[15:8]);
        q.push_back(sample_r[7:0]);
        q.push_back(sample_r[15:8]);
      end
    end
    @(posedge gmii_tx_clk);
    #1;
    cyc++;
    if (wrap_now) last_wrap = cyc;
    chk("sample_ready", 32'(sample_ready), 32'(m_busy == 0));
    chk("fifo_count", 32'(fifo_data_count), 32'(m_count));
    chk("fifo_data", 32'(fifo_data), 32'(m_data));
    chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    pkt_rise = pkt_sync && !prev_pkt;
    if (pkt_rise) begin
      pkt_rises++;
      chk("pkt_rise_latency", 32'(cyc), 32'(last_wrap + 1));
    end
    if (pkt_sync) pkt_hi++;
    if (frame_sync && !prev_frame) begin
      frame_rises++;
      frame_at_pulse = pkt_rises;
      chk("frame_align", 32'(pkt_rise), 32'd1);
    end
    if (frame_sync) frame_hi++;
    prev_pkt   = pkt_sync;
    prev_frame = frame_sync;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_spaced(input int n);
    for (int s = 0; s < n; s++) begin
      send(16'(s * 7 + 3), 16'(s * 13 + 5));
      repeat (4) tick();
    end
  endtask

  initial begin
    int n;
    int ovf_before;

    vecs[0] = '{l: 16'h1234, r: 16'hABCD, exp: {8'hAB, 8'hCD, 8'h12, 8'h34}};
    vecs[1] = '{l: 16'h0000, r: 16'hFFFF, exp: {8'hFF, 8'hFF, 8'h00, 8'h00}};
    vecs[2] = '{l: 16'h8000, r: 16'h7FFF, exp: {8'h7F, 8'hFF, 8'h80, 8'h00}};
    vecs[3] = '{l: 16'hA5C3, r: 16'h0F1E, exp: {8'h0F, 8'h1E, 8'hA5, 8'hC3}};

    rst = 1'b1; flush = 1'b0; sample_valid = 1'b0; fifo_rd_en = 1'b0;
    sample_l = 16'h0; sample_r = 16'h0;

    // Reset values
    repeat (3) @(posedge gmii_tx_clk);
    #1;
    chk("rst_fifo_data", 32'(fifo_data), 32'h0);
    chk("rst_count", 32'(fifo_data_count), 32'h0);
    chk("rst_ready", 32'(sample_ready), 32'h1);
    chk("rst_pkt_sync", 32'(pkt_sync), 32'h0);
    chk("rst_frame_sync", 32'(frame_sync), 32'h0);
    chk("rst_overflow", 32'(overflow_cnt), 32'h0);
    chk("rst_length", 32'(udp_send_data_length), 32'd1024);
    rst = 1'b0;
    tick();

    // Byte order vectors: one sample, ready low 4 cycles, then 4 reads
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].l, vecs[i].r);
      n = 0;
      while (!sample_ready && n < 10) begin
        n++;
        tick();
      end
      chk("vec_ready_low", 32'(n), 32'd4);
      chk("vec_count_full", 32'(fifo_data_count), 32'd4);
      fifo_rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("vec_byte", 32'(fifo_data), 32'(vecs[i].exp[k]));
      end
      fifo_rd_en = 1'b0;
      chk("vec_count_empty", 32'(fifo_data_count), 32'd0);
    end

    // Read from empty FIFO: count and data hold
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    chk("empty_rd_count", 32'(fifo_data_count), 32'd0);
    chk("empty_rd_data", 32'(fifo_data), 32'h0F);

    // Simultaneous write and read leaves the count unchanged
    send(16'h1111, 16'h2222);
    repeat (4) tick();
    send(16'h3333, 16'h4444);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    chk("wr_rd_same_count", 32'(fifo_data_count), 32'd4);
    chk("wr_rd_same_data", 32'(fifo_data), 32'h11);
    repeat (3) tick();

    // Flush while the FSM is writing byte 2
    ovf_before = int'(overflow_cnt);
    send(16'h5555, 16'h6666);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(fifo_data_count), 32'd0);
    chk("flush_ready", 32'(sample_ready), 32'd1);
    chk("flush_ovf_kept", 32'(overflow_cnt), 32'(ovf_before));
    tick();

    // Packet and frame sync with a continuously reading consumer
    pkt_rises = 0; pkt_hi = 0; frame_rises = 0; frame_hi = 0;
    fifo_rd_en = 1'b1;
    send_spaced(256);
    repeat (10) tick();
    chk("pkt_rises_256", 32'(pkt_rises), 32'd1);
    chk("pkt_hi_256", 32'(pkt_hi), 32'd4);
    chk("frame_rises_256", 32'(frame_rises), 32'd0);
    send_spaced(4096 - 256);
    repeat (25) tick();
    fifo_rd_en = 1'b0;
    chk("pkt_rises_4096", 32'(pkt_rises), 32'd16);
    chk("pkt_hi_4096", 32'(pkt_hi), 32'd64);
    chk("frame_rises_4096", 32'(frame_rises), 32'd1);
    chk("frame_hi_4096", 32'(frame_hi), 32'd16);
    chk("frame_at_pulse", 32'(frame_at_pulse), 32'd16);

    // Overflow by filling without reads
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ovf_before = int'(overflow_cnt);
    send_spaced(512);
    chk("ovf_fill_count", 32'(fifo_data_count), 32'd2044);
    chk("ovf_fill_cnt", 32'(overflow_cnt), 32'(ovf_before + 1));

    // Sample arriving while the FSM is busy is dropped
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ovf_before = int'(overflow_cnt);
    send(16'h7777, 16'h8888);
    tick();
    send(16'h9999, 16'hAAAA);
    repeat (4) tick();
    chk("busy_drop_cnt", 32'(overflow_cnt), 32'(ovf_before + 1));
    chk("busy_drop_count", 32'(fifo_data_count), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/audio_udp_packer.md
# audio_udp_packer

Upstream feeder for the UDP transmit controller in the audio-over-Ethernet path. It accepts 16-bit stereo PCM samples in the `gmii_tx_clk` domain and serialises each one into 4 bytes in an internal byte FIFO. It exposes the FIFO read port (`fifo_data`, `fifo_data_count`, `fifo_rd_en`) that the UDP controller consumes. It also generates vsync/href-style framing strobes, which the controller uses for packet gating and identify-code numbering.

## Interface
- `PKT_BYTES`, 1024: payload bytes per UDP packet; must be a multiple of 4.
- `FRAME_PKTS`, 16: packets per frame; sets the `frame_sync` cadence.
- `SYNC_LEN`, 16: `frame_sync` high time, in cycles.
- `ADDR_W`, 11: FIFO address width; capacity is 2^ADDR_W − 1 = 2047 bytes.
- `gmii_tx_clk` in 1: only clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of the FIFO and all counters.
- `sample_valid` in 1: one-cycle strobe that presents a stereo sample.
- `sample_l` in 16: left sample, two's complement.
- `sample_r` in 16: right sample, two's complement.
- `sample_ready` out 1: packer is idle and can accept a sample.
- `fifo_rd_en` in 1: byte read request from the UDP controller.
- `fifo_data` out 8: read data.
- `fifo_data_count` out ADDR_W: FIFO occupancy in bytes.
- `udp_send_data_length` out 16: constant `PKT_BYTES`.
- `pkt_sync` out 1: href-style strobe, one per completed packet.
- `frame_sync` out 1: vsync-style level pulse, one per frame.
- `overflow_cnt` out 16: count of dropped samples; saturates at 16'hFFFF.

## Operation
- **Write FSM states:** `IDLE` → `WB0` → `WB1` → `WB2` → `WB3` → `IDLE`.
  - In `IDLE`, `sample_valid` is accepted only if the FIFO has free space ≥ 4.
  - On acceptance, `{sample_r, sample_l}` is latched into a 32-bit register and the FSM enters `WB0`.
- **Byte order:** `WB0` = L[7:0], `WB1` = L[15:8], `WB2` = R[7:0], `WB3` = R[15:8] (little-endian, L first). One byte is written per cycle.
- **`sample_ready`:** equals (state == `IDLE`).
- **Dropped samples:** a `sample_valid` that arrives while not in `IDLE`, or with free space < 4, is dropped whole and increments `overflow_cnt`. The FIFO never holds a partial sample.
- **FIFO:** circular, 2^ADDR_W entries, one slot always kept empty.
  - Full at count 2047.
  - A read request when the count is 0 is ignored: the pointer does not move and `fifo_data` holds its value.
- **Packet counting:** an ADDR_W-independent 16-bit written-byte counter wraps at `PKT_BYTES`. Each wrap does two things:
  - pulses `pkt_sync` high for 4 cycles;
  - increments the packet counter, which wraps at `FRAME_PKTS`.
- **Frame boundary:** when the packet counter wraps, `frame_sync` is high for `SYNC_LEN` cycles, starting the same cycle as that packet's `pkt_sync`.
- **Flush:** `flush` empties the FIFO (pointers and count to 0) and returns the FSM to `IDLE`. It also clears the byte and packet counters and both sync outputs. `overflow_cnt` is not cleared by `flush`.
- **Priority:** `rst` > `flush` > write/read. When a write and a read occur in the same cycle, the count is unchanged.

## Timing
- **Reset values:** `fifo_data` = 0, `fifo_data_count` = 0, `sample_ready` = 1, `pkt_sync` = 0, `frame_sync` = 0, `overflow_cnt` = 0. `udp_send_data_length` = `PKT_BYTES` at all times.
- **Write latency:** `sample_valid` accepted at edge t writes bytes at edges t+1 through t+4. `sample_ready` is low during cycles t+1..t+4 and high again at t+5. The minimum accepted sample spacing is therefore 5 cycles.
- **Count update:** `fifo_data_count` is registered and reflects a write or read one cycle after the edge that performs it.
- **Read latency:** `fifo_rd_en` at edge t gives the byte on `fifo_data` after edge t+1 (registered, non-FWFT). The byte holds until the next effective read.
- **Sync timing:** `pkt_sync` rises on the edge after the `PKT_BYTES`-th byte is written. A new packet wrap during an active pulse restarts the 4-cycle pulse.
- **Reset mid-operation:** reset or flush mid-sample discards the remaining bytes of that sample.

## Structure
- **Package `audio_eth_pkg`:** the write-FSM state enum, the default `PKT_BYTES`, the sync pulse width 4, and the `overflow_cnt` width.
- **Sub-module `byte_fifo_sc`:** single-clock, parameterised by ADDR_W, with registered read data and count. The FSM, counters and sync generators live in the top module.

## Test plan
- **Reset:** hold `rst` 3 cycles → all outputs at reset values; `udp_send_data_length` = 1024.
- **Single sample:** L = 16'h1234, R = 16'hABCD, then 4 reads → `fifo_data` sequence 8'h34, 8'h12, 8'hCD, 8'hAB; count goes 0→4→0; `sample_ready` is low for exactly 4 cycles.
- **Packet and frame sync:** write 256 samples → exactly one 4-cycle `pkt_sync` pulse, after the 1024th byte. Write 4096 samples → 16 `pkt_sync` pulses and one 16-cycle `frame_sync` aligned with the 16th pulse.
- **Overflow:** no reads, 512 samples at 5-cycle spacing → count saturates at 2044; samples 512 and later are dropped, so `overflow_cnt` = 1. A `sample_valid` at 2-cycle spacing while busy → dropped and counted.
- **Empty read and simultaneous events:** `fifo_rd_en` with count 0 → no change to count or data. A simultaneous write and read → count is unchanged.
- **Flush:** `flush` asserted during `WB2` → count 0, FSM in `IDLE`, `sample_ready` = 1 next cycle, `overflow_cnt` preserved.
